// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing controller: opcodes, FSM states
// and default settle latencies.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEF_ADD_LAT = 1;
    localparam int DEF_SUB_LAT = 1;
    localparam int DEF_MUL_LAT = 2;
    localparam int DEF_DIV_LAT = 4;

    // Largest of the four settle latencies; sizes the settle counter.
    function automatic int max_lat(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first valid requester at or above ptr,
// wrapping around, and reports it both one-hot and encoded.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any
);

    // Walk offsets from farthest to nearest so the nearest valid one wins.
    always_comb begin
        int              cand_i;
        logic [ID_W-1:0] cand;
        grant_idx = '0;
        any       = 1'b0;
        cand_i    = 0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_i = (int'(ptr) + k) % NUM_REQ;
            cand   = cand_i[ID_W-1:0];
            if (valid[cand]) begin
                grant_idx = cand;
                any       = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign grant[gi] = any && (grant_idx == ID_W'(gi));
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational 8-bit ALU between NUM_REQ requesters:
// round-robin grant, operand registers held for a per-opcode settle time,
// then the result is returned on a valid/ready channel tagged with the ID.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int SUB_LAT = DEF_SUB_LAT,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_rs,
    input  logic [NUM_REQ*8-1:0] req_rt,
    input  logic [NUM_REQ*2-1:0] req_op,
    output logic [7:0]           alu_rs,
    output logic [7:0]           alu_rt,
    output logic [1:0]           alu_op,
    input  logic [7:0]           alu_out,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [7:0]           resp_data,
    output logic                 resp_dz,
    output logic                 busy
);

    localparam int CNT_W = $clog2(max_lat(ADD_LAT, SUB_LAT, MUL_LAT, DIV_LAT)) + 1;
    localparam logic [CNT_W-1:0] ADD_CNT = CNT_W'(ADD_LAT - 1);
    localparam logic [CNT_W-1:0] SUB_CNT = CNT_W'(SUB_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_t             state_reg, state_next;
    logic [ID_W-1:0]    ptr_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [7:0]         rs_reg, rt_reg, data_reg;
    logic [1:0]         op_reg;
    logic [ID_W-1:0]    id_reg;
    logic               dz_reg;

    logic [NUM_REQ-1:0] grant_onehot;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic               accept, capture;
    logic [1:0]         grant_op;
    logic [CNT_W-1:0]   load_cnt;
    logic [ID_W-1:0]    ptr_after;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .valid     (req_valid),
        .ptr       (ptr_reg),
        .grant     (grant_onehot),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign grant_op  = req_op[{grant_idx, 1'b0} +: 2];
    assign ptr_after = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Settle count for the opcode being accepted (LAT-1, EXEC lasts LAT cycles).
    always_comb begin
        load_cnt = ADD_CNT;
        case (grant_op)
            OP_ADD:  load_cnt = ADD_CNT;
            OP_SUB:  load_cnt = SUB_CNT;
            OP_MUL:  load_cnt = MUL_CNT;
            default: load_cnt = DIV_CNT;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    // Next state, accept/capture strobes and the request handshake.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        req_ready  = '0;
        case (state_reg)
            ST_IDLE: begin
                // reset_n gate keeps req_ready low while reset is held.
                req_ready = grant_onehot & {NUM_REQ{reset_n}};
                if (grant_any) begin
                    accept     = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_reg == '0) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand latch, settle counter, priority pointer and result capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg  <= '0;
            cnt_reg  <= '0;
            rs_reg   <= '0;
            rt_reg   <= '0;
            op_reg   <= '0;
            id_reg   <= '0;
            data_reg <= '0;
            dz_reg   <= 1'b0;
        end else begin
            if (accept) begin
                rs_reg  <= req_rs[{grant_idx, 3'b000} +: 8];
                rt_reg  <= req_rt[{grant_idx, 3'b000} +: 8];
                op_reg  <= grant_op;
                id_reg  <= grant_idx;
                cnt_reg <= load_cnt;
                ptr_reg <= ptr_after;
            end else if (state_reg == ST_EXEC && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
            if (capture) begin
                // Result passes through untouched; divide-by-zero is only flagged.
                data_reg <= alu_out;
                dz_reg   <= (op_reg == OP_DIV) && (rt_reg == 8'd0);
            end
        end
    end

    assign alu_rs     = rs_reg;
    assign alu_rt     = rt_reg;
    assign alu_op     = op_reg;
    assign resp_valid = (state_reg == ST_RESP);
    assign resp_id    = id_reg;
    assign resp_data  = data_reg;
    assign resp_dz    = dz_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized self-checking bench for alu_share_arbiter with a transaction
// level reference model (priority pointer, expected result and latency).
module tb_alu_share_arbiter;

    localparam int N    = 4;
    localparam int ID_W = $clog2(N);

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*8-1:0] req_rs, req_rt;
    logic [N*2-1:0] req_op;
    logic [7:0]     alu_rs, alu_rt, alu_out, resp_data;
    logic [1:0]     alu_op;
    logic           resp_valid, resp_ready, resp_dz, busy;
    logic [ID_W-1:0] resp_id;

    int total = 0;
    int bad   = 0;
    int model_ptr = 0;

    logic [7:0] rs_a [N];
    logic [7:0] rt_a [N];
    logic [1:0] op_a [N];

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_rt(req_rt), .req_op(req_op),
        .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_op(alu_op), .alu_out(alu_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .resp_dz(resp_dz),
        .busy(busy)
    );

    // The shared 8-bit ALU; divide by zero yields all ones.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
        logic [15:0] p;
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   begin p = a * b; return p[7:0]; end
            default: return (b == 8'd0) ? 8'hFF : a / b;
        endcase
    endfunction

    always_comb alu_out = alu_fn(alu_rs, alu_rt, alu_op);

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b00:   return 1;
            2'b01:   return 1;
            2'b10:   return 2;
            default: return 4;
        endcase
    endfunction

    // First valid requester at or after the model's pointer, wrapping.
    function automatic int pick(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++)
            if (mask[(model_ptr + k) % N]) return (model_ptr + k) % N;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            req_rs[i*8 +: 8] = rs_a[i];
            req_rt[i*8 +: 8] = rt_a[i];
            req_op[i*2 +: 2] = op_a[i];
        end
    endtask

    task automatic rand_ops(input bit small_rt);
        for (int i = 0; i < N; i++) begin
            rs_a[i] = 8'($urandom);
            rt_a[i] = small_rt ? 8'($urandom_range(0, 3)) : 8'($urandom);
            op_a[i] = 2'($urandom);
        end
    endtask

    // One full transaction, entered and left just after a falling edge.
    task automatic do_op(input logic [N-1:0] vmask, input bit keep, input int bp);
        int g, lat;
        logic [7:0] ers, ert, edata;
        logic [1:0] eop;
        logic edz;
        logic [N-1:0] exp_rdy;
        req_valid  = vmask;
        drive_bus();
        resp_ready = (bp == 0);
        #1;
        g       = pick(vmask);
        exp_rdy = '0;
        exp_rdy[g] = 1'b1;
        check("req_ready_grant", 32'(req_ready), 32'(exp_rdy));
        check("idle_busy", 32'(busy), 0);
        check("idle_resp_valid", 32'(resp_valid), 0);
        ers = rs_a[g]; ert = rt_a[g]; eop = op_a[g];
        lat   = lat_of(eop);
        edata = alu_fn(ers, ert, eop);
        edz   = (eop == 2'b11) && (ert == 8'd0);
        model_ptr = (g + 1) % N;
        @(posedge clk);
        @(negedge clk);
        if (!keep) req_valid = '0;
        for (int c = 1; c <= lat; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i]) begin
                    rs_a[i] = 8'($urandom);
                    rt_a[i] = 8'($urandom);
                end
            drive_bus();
            #1;
            check("exec_alu_rs", 32'(alu_rs), 32'(ers));
            check("exec_alu_rt", 32'(alu_rt), 32'(ert));
            check("exec_alu_op", 32'(alu_op), 32'(eop));
            check("exec_resp_valid", 32'(resp_valid), 0);
            check("exec_busy", 32'(busy), 1);
            check("exec_req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        #1;
        check("resp_valid", 32'(resp_valid), 1);
        check("resp_id", 32'(resp_id), 32'(g));
        check("resp_data", 32'(resp_data), 32'(edata));
        check("resp_dz", 32'(resp_dz), 32'(edz));
        for (int b = 0; b < bp; b++) begin
            req_valid = '1;
            @(negedge clk);
            if (b == bp - 1) resp_ready = 1'b1;
            #1;
            check("stall_resp_valid", 32'(resp_valid), 1);
            check("stall_resp_id", 32'(resp_id), 32'(g));
            check("stall_resp_data", 32'(resp_data), 32'(edata));
            check("stall_req_ready", 32'(req_ready), 0);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        check("post_resp_valid", 32'(resp_valid), 0);
        check("post_busy", 32'(busy), 0);
        $display("op id=%0d opc=%0d rs=%0h rt=%0h data=%0h dz=%0d lat=%0d bp=%0d",
                 g, eop, ers, ert, edata, edz, lat, bp);
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = '1;
        resp_ready = 1'b0;
        rand_ops(1'b0);
        drive_bus();
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_data", 32'(resp_data), 0);
        check("rst_resp_dz", 32'(resp_dz), 0);
        check("rst_alu_rs", 32'(alu_rs), 0);
        @(negedge clk);
        reset_n   = 1'b1;
        req_valid = '0;
        model_ptr = 0;
        @(negedge clk);

        // Single ADD from requester 2: 5 + 3.
        rand_ops(1'b0);
        rs_a[2] = 8'h05; rt_a[2] = 8'h03; op_a[2] = 2'b00;
        do_op(4'b0100, 1'b0, 0);

        // DIV 20/6 from requester 1, then DIV by zero from requester 0.
        rs_a[1] = 8'd20; rt_a[1] = 8'd6; op_a[1] = 2'b11;
        do_op(4'b0010, 1'b0, 0);
        rs_a[0] = 8'd9; rt_a[0] = 8'd0; op_a[0] = 2'b11;
        do_op(4'b0001, 1'b0, 0);

        // Reset in the middle of a DIV from requester 3.
        rs_a[3] = 8'd100; rt_a[3] = 8'd7; op_a[3] = 2'b11;
        req_valid = 4'b1000;
        drive_bus();
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        req_valid = '1;
        reset_n   = 1'b0;
        #1;
        check("midrst_resp_valid", 32'(resp_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_req_ready", 32'(req_ready), 0);
        check("midrst_alu_op", 32'(alu_op), 0);
        @(negedge clk);
        reset_n   = 1'b1;
        model_ptr = 0;

        // Fairness: all valid, MUL 16*17 each; grants 0,1,2,3,0.
        for (int i = 0; i < N; i++) begin
            rs_a[i] = 8'd16; rt_a[i] = 8'd17; op_a[i] = 2'b10;
        end
        for (int t = 0; t < 5; t++) do_op('1, 1'b1, 0);

        // Back-pressure for 5 cycles.
        rand_ops(1'b0);
        do_op(4'b0110, 1'b0, 5);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            rand_ops(1'b1);
            if ($urandom_range(0, 1) == 1)
                for (int i = 0; i < N; i++) rt_a[i] = 8'($urandom);
            do_op(4'($urandom_range(1, (1 << N) - 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
